// File: rtl/mod_down_counter_prog.sv
// Run-time programmable modulo down-counter: counts a loaded value down to zero,
// then stops (one-shot) or reloads (auto-reload) and emits a one-cycle done pulse.
module mod_down_counter_prog #(
    parameter int BITS = 4
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            load,
    input  logic [BITS-1:0] load_val,
    input  logic            enable,
    input  logic            mode,
    output logic [BITS-1:0] Q,
    output logic            busy,
    output logic            done
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t          state;
    logic [BITS-1:0] q_reg;
    logic [BITS-1:0] reload_reg;
    logic            done_reg;

    // Load always wins over counting; zero is handled as the terminal event,
    // so the decrement can never wrap below zero.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            q_reg      <= '0;
            reload_reg <= '0;
            done_reg   <= 1'b0;
        end else if (load) begin
            reload_reg <= load_val;
            q_reg      <= load_val;
            done_reg   <= 1'b0;
            state      <= (load_val != '0) ? RUN : IDLE;
        end else begin
            case (state)
                IDLE: begin
                    done_reg <= 1'b0;
                end
                RUN: begin
                    if (!enable) begin
                        done_reg <= 1'b0;
                    end else if (q_reg != '0) begin
                        q_reg    <= q_reg - 1'b1;
                        done_reg <= 1'b0;
                    end else begin
                        done_reg <= 1'b1;
                        if (mode) begin
                            q_reg <= reload_reg;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                default: begin
                    state    <= IDLE;
                    done_reg <= 1'b0;
                end
            endcase
        end
    end

    assign Q    = q_reg;
    assign busy = (state == RUN);
    assign done = done_reg;

endmodule

// File: tb/tb_mod_down_counter_prog.sv
// Self-checking bench for mod_down_counter_prog: directed scenarios plus random
// traffic, all checked against a cycle-level behavioural model of the counter.
module tb_mod_down_counter_prog;

    localparam int BITS = 4;
    localparam int MAXV = (1 << BITS) - 1;

    logic            clk = 1'b0;
    logic            reset_n = 1'b0;
    logic            load = 1'b0;
    logic [BITS-1:0] load_val = '0;
    logic            enable = 1'b0;
    logic            mode = 1'b0;
    logic [BITS-1:0] Q;
    logic            busy;
    logic            done;

    int n_cmp = 0;
    int n_err = 0;

    // Behavioural model: remaining count, whether a countdown is active, reload value.
    int m_count = 0;
    int m_reload = 0;
    bit m_active = 1'b0;
    bit m_done = 1'b0;

    mod_down_counter_prog #(.BITS(BITS)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .load     (load),
        .load_val (load_val),
        .enable   (enable),
        .mode     (mode),
        .Q        (Q),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_count = 0;
        m_reload = 0;
        m_active = 1'b0;
        m_done = 1'b0;
    endtask

    task automatic model_edge();
        m_done = 1'b0;
        if (load) begin
            m_reload = int'(load_val);
            m_count = int'(load_val);
            m_active = (load_val != 0);
        end else if (m_active && enable) begin
            if (m_count > 0) begin
                m_count = m_count - 1;
            end else begin
                m_done = 1'b1;
                if (mode) m_count = m_reload;
                else m_active = 1'b0;
            end
        end
    endtask

    // Advance one clock edge, update the model with the inputs seen at that edge.
    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        n_cmp++;
        if ({Q, busy, done} !== {m_count[BITS-1:0], m_active, m_done}) begin
            n_err++;
            $display("[TB] FAIL reset_state: got Q=%0d busy=%0b done=%0b want Q=0 busy=0 done=0", Q, busy, done);
        end
        reset_n = 1'b1;
        enable = 1'b1;
        mode = 1'b1;
        repeat (4) begin
            tick();
            n_cmp++;
            if ({Q, busy, done} !== {BITS'(0), 1'b0, 1'b0}) begin
                n_err++;
                $display("[TB] FAIL idle_after_reset: got Q=%0d busy=%0b done=%0b want 0/0/0", Q, busy, done);
            end
        end
        enable = 1'b0;
    endtask

    task automatic test_one_shot();
        int pulses = 0;
        load = 1'b1; load_val = 5; mode = 1'b0; enable = 1'b1;
        tick();
        load = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (done) pulses++;
            n_cmp++;
            if ({Q, busy, done} !== {m_count[BITS-1:0], m_active, m_done}) begin
                n_err++;
                $display("[TB] FAIL one_shot cyc%0d: got Q=%0d busy=%0b done=%0b want Q=%0d busy=%0b done=%0b",
                         i, Q, busy, done, m_count, m_active, m_done);
            end
        end
        n_cmp++;
        if (pulses != 1 || Q !== 0 || busy !== 1'b0) begin
            n_err++;
            $display("[TB] FAIL one_shot_final: got pulses=%0d Q=%0d busy=%0b want 1/0/0", pulses, Q, busy);
        end
        enable = 1'b0;
    endtask

    task automatic test_auto_reload();
        int pulses = 0;
        bit busy_dropped = 1'b0;
        load = 1'b1; load_val = 7; mode = 1'b1; enable = 1'b1;
        tick();
        load = 1'b0;
        for (int i = 0; i < 24; i++) begin
            tick();
            if (done) pulses++;
            if (!busy) busy_dropped = 1'b1;
            n_cmp++;
            if ({Q, done} !== {BITS'(7 - ((i + 1) % 8)), ((i % 8) == 7)}) begin
                n_err++;
                $display("[TB] FAIL auto_reload cyc%0d: got Q=%0d done=%0b want Q=%0d done=%0b",
                         i, Q, done, 7 - ((i + 1) % 8), ((i % 8) == 7));
            end
        end
        n_cmp++;
        if (pulses != 3 || busy_dropped) begin
            n_err++;
            $display("[TB] FAIL auto_reload_summary: got pulses=%0d busy_dropped=%0b want 3/0", pulses, busy_dropped);
        end
        enable = 1'b0;
    endtask

    task automatic test_enable_toggle();
        int first_done = -1;
        int enabled_edges = 0;
        load = 1'b1; load_val = 3; mode = 1'b1; enable = 1'b0;
        tick();
        load = 1'b0;
        for (int i = 0; i < 16; i++) begin
            enable = (i % 2 == 0);
            tick();
            if (enable) enabled_edges++;
            if (done && first_done < 0) first_done = enabled_edges;
            n_cmp++;
            if ({Q, busy, done} !== {m_count[BITS-1:0], m_active, m_done}) begin
                n_err++;
                $display("[TB] FAIL enable_toggle cyc%0d: got Q=%0d busy=%0b done=%0b want Q=%0d busy=%0b done=%0b",
                         i, Q, busy, done, m_count, m_active, m_done);
            end
        end
        n_cmp++;
        if (first_done != 4) begin
            n_err++;
            $display("[TB] FAIL enable_toggle_first_done: got after %0d enabled edges want 4", first_done);
        end
        enable = 1'b0;
    endtask

    task automatic test_load_at_terminal();
        load = 1'b1; load_val = 2; mode = 1'b1; enable = 1'b1;
        tick();
        load = 1'b0;
        repeat (2) tick();
        n_cmp++;
        if (Q !== 0) begin
            n_err++;
            $display("[TB] FAIL load_term_setup: got Q=%0d want 0", Q);
        end
        load = 1'b1; load_val = 9;
        tick();
        load = 1'b0; enable = 1'b0;
        n_cmp++;
        if ({Q, busy, done} !== {BITS'(9), 1'b1, 1'b0}) begin
            n_err++;
            $display("[TB] FAIL load_term: got Q=%0d busy=%0b done=%0b want Q=9 busy=1 done=0", Q, busy, done);
        end
        tick();
        n_cmp++;
        if (done !== 1'b0 || Q !== 9) begin
            n_err++;
            $display("[TB] FAIL load_term_after: got Q=%0d done=%0b want Q=9 done=0", Q, done);
        end
    endtask

    task automatic test_load_zero_and_max();
        int pulses = 0;
        int last = -1;
        load = 1'b1; load_val = 0; mode = 1'b1; enable = 1'b1;
        tick();
        load = 1'b0;
        repeat (4) begin
            tick();
            n_cmp++;
            if ({Q, busy, done} !== {BITS'(0), 1'b0, 1'b0}) begin
                n_err++;
                $display("[TB] FAIL load_zero: got Q=%0d busy=%0b done=%0b want 0/0/0", Q, busy, done);
            end
        end
        load = 1'b1; load_val = BITS'(MAXV);
        tick();
        load = 1'b0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (done) begin
                pulses++;
                if (last >= 0) begin
                    n_cmp++;
                    if (i - last != MAXV + 1) begin
                        n_err++;
                        $display("[TB] FAIL max_period: got %0d want %0d", i - last, MAXV + 1);
                    end
                end
                last = i;
            end
            n_cmp++;
            if ({Q, busy, done} !== {m_count[BITS-1:0], m_active, m_done}) begin
                n_err++;
                $display("[TB] FAIL max_load cyc%0d: got Q=%0d busy=%0b done=%0b want Q=%0d busy=%0b done=%0b",
                         i, Q, busy, done, m_count, m_active, m_done);
            end
        end
        n_cmp++;
        if (pulses != 2) begin
            n_err++;
            $display("[TB] FAIL max_pulses: got %0d want 2", pulses);
        end
        enable = 1'b0;
    endtask

    task automatic test_mid_reset();
        load = 1'b1; load_val = 10; mode = 1'b0; enable = 1'b1;
        tick();
        load = 1'b0;
        repeat (4) tick();
        n_cmp++;
        if (Q !== 6) begin
            n_err++;
            $display("[TB] FAIL mid_reset_setup: got Q=%0d want 6", Q);
        end
        #2 reset_n = 1'b0;
        #1;
        model_reset();
        n_cmp++;
        if ({Q, busy, done} !== {BITS'(0), 1'b0, 1'b0}) begin
            n_err++;
            $display("[TB] FAIL mid_reset_async: got Q=%0d busy=%0b done=%0b want 0/0/0", Q, busy, done);
        end
        #1 reset_n = 1'b1;
        repeat (5) begin
            tick();
            n_cmp++;
            if ({Q, busy, done} !== {BITS'(0), 1'b0, 1'b0}) begin
                n_err++;
                $display("[TB] FAIL post_reset_idle: got Q=%0d busy=%0b done=%0b want 0/0/0", Q, busy, done);
            end
        end
        enable = 1'b0;
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            load = ($urandom_range(0, 9) == 0);
            load_val = BITS'($urandom_range(0, MAXV));
            enable = ($urandom_range(0, 3) != 0);
            mode = $urandom_range(0, 1) != 0;
            tick();
            n_cmp++;
            if ({Q, busy, done} !== {m_count[BITS-1:0], m_active, m_done}) begin
                n_err++;
                $display("[TB] FAIL random cyc%0d: got Q=%0d busy=%0b done=%0b want Q=%0d busy=%0b done=%0b",
                         i, Q, busy, done, m_count, m_active, m_done);
            end
        end
        load = 1'b0;
        enable = 1'b0;
    endtask

    initial begin
        test_reset();
        test_one_shot();
        test_auto_reload();
        test_enable_toggle();
        test_load_at_terminal();
        test_load_zero_and_max();
        test_mid_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
